// File: rtl/sub_16_pipe_pkg.sv
// Shared widths and stage payload types for the two-stage 16-bit subtractor.
package sub_16_pipe_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned SLICE_W     = 8;
    localparam int unsigned PREFIX_LVLS = 3;

    // Low byte resolved, high byte operands carried forward with the mid borrow.
    typedef struct packed {
        logic [SLICE_W-1:0] d_lo;
        logic               b_mid;
        logic [SLICE_W-1:0] a_hi;
        logic [SLICE_W-1:0] b_hi;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] q;
        logic              bout;
        logic              zero;
        logic              ovf;
    } s2_t;

endpackage

// File: rtl/sub_8_slice.sv
// Combinational 8-bit subtract slice (x - y - bin) with a parallel-prefix borrow network.
module sub_8_slice
    import sub_16_pipe_pkg::*;
(
    input  logic [SLICE_W-1:0] i_x,
    input  logic [SLICE_W-1:0] i_y,
    input  logic               i_bin,
    output logic [SLICE_W-1:0] o_d,
    output logic               o_bout
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_bi;

    // Borrow generate where x<y per bit, propagate where x==y; bin folded into bit 0.
    // Descending in-place update keeps each level reading the previous level's values.
    always_comb begin
        w_g    = ~i_x & i_y;
        w_p    = ~(i_x ^ i_y);
        w_g[0] = w_g[0] | (w_p[0] & i_bin);
        for (int lv = 0; lv < int'(PREFIX_LVLS); lv++) begin
            for (int i = int'(SLICE_W) - 1; i >= 0; i--) begin
                if (i >= (1 << lv)) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lv)]);
                    w_p[i] = w_p[i] & w_p[i - (1 << lv)];
                end
            end
        end
        w_bi = {w_g[SLICE_W-2:0], i_bin};
    end

    assign o_d    = i_x ^ i_y ^ w_bi;
    assign o_bout = w_g[SLICE_W-1];

endmodule

// File: rtl/sub_16_pipe.sv
// Two-stage pipelined 16-bit subtractor with valid/ready handshakes on both sides.
module sub_16_pipe
    import sub_16_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] q,
    output logic              bout,
    output logic              zero,
    output logic              ovf
);

    logic r_v1;
    logic r_v2;
    s1_t  r_s1;
    s2_t  r_s2;

    logic               w_s2_free;
    logic               w_s1_free;
    logic               w_accept;
    logic [SLICE_W-1:0] w_d_lo;
    logic               w_b_mid;
    logic [SLICE_W-1:0] w_d_hi;
    logic               w_b_hi;
    logic [DATA_W-1:0]  w_q;
    logic               w_ovf;

    assign w_s2_free = !r_v2 || out_ready;
    assign w_s1_free = !r_v1 || w_s2_free;
    assign w_accept  = in_valid && w_s1_free;

    sub_8_slice u_slice_lo (
        .i_x    (a[SLICE_W-1:0]),
        .i_y    (b[SLICE_W-1:0]),
        .i_bin  (bin),
        .o_d    (w_d_lo),
        .o_bout (w_b_mid)
    );

    sub_8_slice u_slice_hi (
        .i_x    (r_s1.a_hi),
        .i_y    (r_s1.b_hi),
        .i_bin  (r_s1.b_mid),
        .o_d    (w_d_hi),
        .o_bout (w_b_hi)
    );

    assign w_q   = {w_d_hi, r_s1.d_lo};
    assign w_ovf = (r_s1.a_hi[SLICE_W-1] ^ r_s1.b_hi[SLICE_W-1])
                 & (w_q[DATA_W-1] ^ r_s1.a_hi[SLICE_W-1]);

    // Each stage loads only when the stage ahead of it is free to take its contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            if (w_s1_free) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_s1 <= '{d_lo:  w_d_lo,
                              b_mid: w_b_mid,
                              a_hi:  a[DATA_W-1:SLICE_W],
                              b_hi:  b[DATA_W-1:SLICE_W]};
                end
            end
            if (w_s2_free) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2 <= '{q:    w_q,
                              bout: w_b_hi,
                              zero: (w_q == '0),
                              ovf:  w_ovf};
                end
            end
        end
    end

    assign in_ready  = w_s1_free;
    assign out_valid = r_v2;
    assign q         = r_s2.q;
    assign bout      = r_s2.bout;
    assign zero      = r_s2.zero;
    assign ovf       = r_s2.ovf;

endmodule

// File: tb/tb_sub_16_pipe.sv
// Scoreboard bench for sub_16_pipe: directed corner cases, backpressure, reset and a random stream.
module tb_sub_16_pipe;

    typedef struct packed {
        logic [15:0] q;
        logic        bout;
        logic        zero;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        bout;
    logic        zero;
    logic        ovf;

    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    sub_16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        res_t r;
        int   diff;
        diff   = int'(ma) - int'(mb) - int'(mbin);
        r.q    = 16'(diff);
        r.bout = (diff < 0);
        r.zero = (r.q == 16'd0);
        r.ovf  = (ma[15] != mb[15]) && (r.q[15] != ma[15]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of drive; pushes the expected result when the operand set is taken.
    task automatic cyc(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ibin, input logic ordy, input res_t exp, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(exp);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
    endtask

    task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ibin, input res_t exp);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cyc(1'b1, ia, ib, ibin, 1'b1, exp, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    // Monitor: pops on every output transfer and checks that stalled outputs hold still.
    initial begin : monitor
        res_t held;
        res_t got;
        res_t exp;
        logic have_hold;
        have_hold = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                have_hold = 1'b0;
            end else begin
                got = '{q: q, bout: bout, zero: zero, ovf: ovf};
                if (have_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(got), 32'(held));
                end
                have_hold = out_valid && !out_ready;
                held      = got;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(got), 32'hDEAD);
                    end else begin
                        exp = sb.pop_front();
                        chk("result", 32'(got), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic acc;
        int   accepted;
        int   cycles;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic subtraction and two-cycle latency
        cyc(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1, '{16'h1000, 1'b0, 1'b0, 1'b0}, acc);
        chk("basic_accept", 32'(acc), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
        chk("latency_cycle1", 32'(out_valid), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
        chk("latency_cycle2", 32'(out_valid), 32'd1);

        send(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b1});
        send(16'h00FF, 16'h00FE, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0});
        send(16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
        idle(4);

        // Backpressure: out_ready low for 4 cycles with 3 back-to-back inputs
        cyc(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0, '{16'h00FF, 1'b0, 1'b0, 1'b0}, acc);
        chk("bp_acc0", 32'(acc), 32'd1);
        cyc(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, acc);
        chk("bp_acc1", 32'(acc), 32'd1);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0}, acc);
        chk("bp_in_ready_low2", 32'(in_ready), 32'd0);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0}, acc);
        chk("bp_in_ready_low3", 32'(in_ready), 32'd0);
        chk("bp_first_q_held", 32'(q), 32'h00FF);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0}, acc);
        chk("bp_acc2", 32'(acc), 32'd1);
        chk("bp_out0_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
        chk("bp_out1_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        idle(3);

        // Reset with two operations in flight
        cyc(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, model(16'h4444, 16'h1111, 1'b0), acc);
        chk("rst_flight_acc0", 32'(acc), 32'd1);
        cyc(1'b1, 16'h5555, 16'h2222, 1'b0, 1'b0, model(16'h5555, 16'h2222, 1'b0), acc);
        chk("rst_flight_acc1", 32'(acc), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        idle(5);

        // Random stream
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                ra = 16'($urandom_range(1, 0)) ? 16'h8000 : 16'h0000;
                rb = 16'($urandom_range(2, 0));
            end
            cyc(1'($urandom_range(9, 0) < 8), ra, rb, rbin, 1'($urandom), model(ra, rb, rbin), acc);
            if (acc) accepted++;
            cycles++;
        end
        chk("random_accepted", 32'(accepted), 32'd10000);

        cycles = 0;
        while (sb.size() != 0 && cycles < 20) begin
            idle(1);
            cycles++;
        end
        idle(2);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
